mdu_iter: RTL and testbench



---
 rtl/mdu_if.sv | 28 ++
 rtl/mdu_iter.sv | 153 +++++++++++++++
 tb/tb_mdu_iter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one shift step per cycle.
// Optional MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier is zero.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_lo, neg_hi;
  logic [PW-1:0]    opa, acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q, busy_q, done_q;

  logic             accept, zero_div, early, finish, run_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    mul_acc, prod;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, res_hi, res_lo;

  // Signed ops iterate on magnitudes; signs are re-applied on the final step.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.op[0] && bus.a[WIDTH-1]) a_mag = WIDTH'(-bus.a);
    if (bus.op[0] && bus.b[WIDTH-1]) b_mag = WIDTH'(-bus.b);
  end

  // One shift-add or restoring shift-subtract step, plus the sign-corrected result.
  always_comb begin
    mul_acc = opb[0] ? acc + opa : acc;
    r_sh    = {acc[WIDTH-1:0], opb[WIDTH-1]};
    ge      = r_sh >= {1'b0, opa[WIDTH-1:0]};
    rem_nxt = ge ? WIDTH'(r_sh - {1'b0, opa[WIDTH-1:0]}) : r_sh[WIDTH-1:0];
    quo_nxt = {opb[WIDTH-2:0], ge};
    prod    = neg_lo ? PW'(-mul_acc) : mul_acc;
    if (is_div) begin
      res_lo = neg_lo ? WIDTH'(-quo_nxt) : quo_nxt;
      res_hi = neg_hi ? WIDTH'(-rem_nxt) : rem_nxt;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[PW-1:WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    run_step  = 1'b0;
    early     = 1'b0;
    zero_div  = bus.op[1] && (bus.b == '0);
`ifdef MDU_EARLY_OUT_EN
    early     = !is_div && ((opb >> 1) == '0);
`endif
    case (state)
      S_RUN: begin
        if (bus.flush) begin
          state_nxt = S_IDLE;
        end else begin
          run_step = 1'b1;
          if ((cnt == '0) || early) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_nxt = S_IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = zero_div ? S_DONE : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == S_RUN);
      done_q <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_W'(WIDTH - 1);
      is_div <= bus.op[1];
      neg_lo <= bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_hi <= bus.op[0] && bus.a[WIDTH-1];
      opa    <= PW'(bus.op[1] ? b_mag : a_mag);
      opb    <= bus.op[1] ? a_mag : b_mag;
      acc    <= '0;
      dbz_q  <= zero_div;
      if (zero_div) begin
        hi_q <= bus.a;
        lo_q <= '1;
      end
    end else if (run_step) begin
      cnt <= cnt - CNT_W'(1);
      if (is_div) begin
        acc <= PW'(rem_nxt);
        opb <= quo_nxt;
      end else begin
        acc <= mul_acc;
        opa <= opa << 1;
        opb <= opb >> 1;
      end
      if (finish) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (state != S_RUN) begin
      // MTHI/MTLO only land when the unit is not computing and no start was taken.
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table plus scoreboard, with hand-written flush/reset/MTHI sequences.
module tb_mdu_iter;
  localparam int unsigned W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  mdu_if #(.WIDTH(W)) bus();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int exp_cycles(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1]) return (b == '0) ? 0 : int'(W);
`ifdef MDU_EARLY_OUT_EN
    begin
      logic [W-1:0] mag;
      int n;
      mag = (op[0] && b[W-1]) ? W'(-b) : b;
      n = 1;
      for (int i = 0; i < int'(W); i++) if (mag[i]) n = i + 1;
      return n;
    end
`else
    return int'(W);
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.cyc = exp_cycles(op, b);
    sa  = op[0] ? longint'(signed'(a)) : longint'(64'(a));
    sbv = op[0] ? longint'(signed'(b)) : longint'(64'(b));
    if (!op[1]) begin
      p = 64'(sa * sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dbz = 1'b1;
    end else begin
      e.lo = W'(sa / sbv);
      e.hi = W'(sa % sbv);
    end
    return e;
  endfunction

  task automatic start_raw(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    sb_q.push_back(e);
    start_raw(op, a, b);
  endtask

  // Waits for done, counting busy cycles; optionally pokes start+MTHI at busy cycle `inject`.
  task automatic wait_done(input int inject);
    int cnt;
    bit seen;
    exp_t e;
    cnt = 0;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (bus.done) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none pending");
        end else begin
          e = sb_q.pop_front();
          chk("hi", 64'(bus.hi), 64'(e.hi));
          chk("lo", 64'(bus.lo), 64'(e.lo));
          chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          chk("busy_cycles", 64'(cnt), 64'(e.cyc));
        end
      end else begin
        if (bus.busy) cnt++;
        if (inject != 0 && cnt == inject) begin
          bus.start = 1'b1;
          bus.op = 2'b10;
          bus.a = 32'd100;
          bus.b = 32'd7;
          bus.hi_we = 1'b1;
          bus.wdata = 32'h12345678;
        end else begin
          bus.start = 1'b0;
          bus.hi_we = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset = 1'b1;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0};
    vecs[7]  = '{2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);

    // Back-to-back: each vector is issued in the DONE cycle of the previous one.
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.dbz = vecs[i].dbz;
      e.cyc = exp_cycles(vecs[i].op, vecs[i].b);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, e);
      wait_done(0);
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      issue(rop, ra, rb, model(rop, ra, rb));
      wait_done(0);
    end

    // Start and MTHI while busy must both be ignored.
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, model(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF));
    wait_done(5);
    @(negedge clk);
    chk("ignored_start_busy", 64'(bus.busy), 64'd0);
    chk("ignored_start_done", 64'(bus.done), 64'd0);

    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h12345678);
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo", 64'(bus.lo), 64'hCAFEF00D);
    chk("mtlo_keeps_hi", 64'(bus.hi), 64'h12345678);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h55AA55AA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mthi_lo_hi", 64'(bus.hi), 64'h55AA55AA);
    chk("mthi_lo_lo", 64'(bus.lo), 64'h55AA55AA);

    // Flush at busy cycle 10: back to idle, no done, HI/LO untouched.
    start_raw(2'b00, 32'd6, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    chk("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_done", 64'(bus.done), 64'd0);
      @(negedge clk);
    end
    chk("flush_hi", 64'(bus.hi), 64'h55AA55AA);
    chk("flush_lo", 64'(bus.lo), 64'h55AA55AA);

    // Start wins over a simultaneous MTHI.
    bus.hi_we = 1'b1; bus.wdata = 32'hFFFF0000;
    issue(2'b00, 32'd2, 32'd3, model(2'b00, 32'd2, 32'd3));
    bus.hi_we = 1'b0;
    chk("start_over_mthi", 64'(bus.hi), 64'h55AA55AA);
    wait_done(0);

    // Reset mid-operation discards everything.
    start_raw(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_run_busy", 64'(bus.busy), 64'd0);
    chk("rst_run_done", 64'(bus.done), 64'd0);
    chk("rst_run_hi", 64'(bus.hi), 64'd0);
    chk("rst_run_lo", 64'(bus.lo), 64'd0);
    chk("rst_run_dbz", 64'(bus.div_by_zero), 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_run_no_done", 64'(bus.done), 64'd0);
    chk("rst_run_lo_stays", 64'(bus.lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
